spi_pwm_master: RTL and testbench

Host-side SPI initiator that drives the PWM IO expander's SPI port. A local controller requests a two-byte write transaction (address byte, then data byte). The block generates `_CS`, `SCLK` and `MOSI` in SPI mode 0, samples `MISO` during the data byte, and reports completion with a handshake. It is the opposite end of the expander's SPI slave, and its output pins wire directly to the expander's `_CS`/`SCLK`/`MOSI`/`MISO`.

---
 rtl/spi_pwm_master.sv | 150 +++++++++++++++
 tb/tb_spi_pwm_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_master.sv
// SPI mode-0 initiator for the PWM IO expander.
// Sends {Address, DataIn} MSB first and returns the MISO byte seen during DataIn.
module spi_pwm_master #(
    parameter int ClkDiv = 4
) (
    input  logic       CLK,
    input  logic       _RST,
    input  logic       Start,
    input  logic [7:0] Address,
    input  logic [7:0] DataIn,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] RXData,
    output logic       _CS,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int CW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CW-1:0] CntMax = CW'(ClkDiv - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [14:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rxdata_q, rxdata_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rxdata_d = rxdata_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Start) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = Address[7];
                    tx_d    = {Address[6:0], DataIn};
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], MISO};
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 5'd1;
                        if (bit_q != 5'd15) begin
                            mosi_d = tx_q[14];
                            tx_d   = {tx_q[13:0], 1'b0};
                        end
                    // the 16th period still owns its low phase before HOLD
                    end else if (bit_q == 5'd16) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], MISO};
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = GAP;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    rxdata_d = rx_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rx_q keeps only the newest 8 MISO bits, which are the data-byte bits
    always_ff @(posedge CLK) begin
        if (!_RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rxdata_q <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rxdata_q <= rxdata_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign _CS    = cs_q;
    assign SCLK   = sclk_q;
    assign MOSI   = mosi_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign RXData = rxdata_q;

endmodule

// File: tb/tb_spi_pwm_master.sv
// Directed bench for spi_pwm_master with a mode-0 slave model.
// Covers ClkDiv=2 framing, ignored restart, mid-frame reset and ClkDiv=1 back-to-back.
module tb_spi_pwm_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] addr, data;
    logic       busy, done, cs_n, sclk, mosi;
    logic       miso = 1'b0;
    logic [7:0] rxd;

    logic       start1;
    logic [7:0] addr1 = 8'h5A;
    logic [7:0] data1 = 8'hC3;
    logic       busy1, done1, cs1_n, sclk1, mosi1;
    logic       miso1 = 1'b1;
    logic [7:0] rxd1;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_pwm_master #(.ClkDiv(2)) dut (
        .CLK(clk), ._RST(rst_n), .Start(start), .Address(addr),
        .DataIn(data), .Busy(busy), .Done(done), .RXData(rxd),
        ._CS(cs_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    spi_pwm_master #(.ClkDiv(1)) dut1 (
        .CLK(clk), ._RST(rst_n), .Start(start1), .Address(addr1),
        .DataIn(data1), .Busy(busy1), .Done(done1), .RXData(rxd1),
        ._CS(cs1_n), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1)
    );

    // slave model: capture MOSI on rise, shift MISO out on fall
    logic [15:0] miso_word = '0;
    logic [15:0] srx = '0;
    int          rises = 0;
    int          sidx = 0;
    bit          in_frame = 0;

    always @(cs_n or sclk) begin
        if (cs_n) begin
            in_frame = 0;
        end else if (!in_frame) begin
            in_frame = 1;
            sidx = 0;
            rises = 0;
            srx = '0;
            miso = miso_word[15];
        end else if (sclk) begin
            srx = {srx[14:0], mosi};
            rises++;
        end else begin
            sidx++;
            if (sidx < 16) miso = miso_word[15-sidx];
        end
    end

    int cs_low = 0;
    int done_cnt = 0;
    int first_rise = -1;
    int acc[$];
    int d1[$];
    logic busy1_prev = 1'b0;

    always @(negedge clk) begin
        if (!cs_n) cs_low++;
        if (done) done_cnt++;
        if (sclk && first_rise < 0) first_rise = cyc;
        if (busy1 && !busy1_prev) acc.push_back(cyc);
        if (done1) d1.push_back(cyc);
        busy1_prev = busy1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic [7:0] a, input logic [7:0] d,
                             input logic [15:0] w, output int e0);
        @(negedge clk);
        addr = a;
        data = d;
        miso_word = w;
        cs_low = 0;
        done_cnt = 0;
        first_rise = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int limit, output int at, output bit ok);
        ok = 0;
        at = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                at = cyc;
            end
        end
    endtask

    int e0, at;
    bit ok;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        addr = '0;
        data = '0;
        repeat (3) @(negedge clk);
        check("rst_cs", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rxd", rxd, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        start_txn(8'h00, 8'h80, 16'h3CA5, e0);
        check("t1_busy_start", busy, 1);
        check("t1_cs_start", cs_n, 0);
        wait_done(200, at, ok);
        check("t1_done_seen", ok, 1);
        check("t1_done_time", at - e0, 70);
        check("t1_busy_at_done", busy, 0);
        check("t1_rxd", rxd, 8'hA5);
        check("t1_slave_rx", srx, 16'h0080);
        check("t1_rises", rises, 16);
        check("t1_cs_low", cs_low, 68);
        check("t1_first_rise", first_rise - e0, 2);
        @(negedge clk);
        check("t1_done_width", done, 0);

        start_txn(8'h12, 8'h34, 16'h0000, e0);
        while (cyc < e0 + 9) @(negedge clk);
        addr = 8'hFF;
        data = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t2_busy_mid", busy, 1);
        wait_done(200, at, ok);
        check("t2_done_seen", ok, 1);
        check("t2_done_time", at - e0, 70);
        check("t2_slave_rx", srx, 16'h1234);
        check("t2_rxd", rxd, 8'h00);
        repeat (10) @(negedge clk);
        check("t2_done_count", done_cnt, 1);

        start_txn(8'hAA, 8'h55, 16'hFFFF, e0);
        while (cyc < e0 + 19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t3_cs", cs_n, 1);
        check("t3_sclk", sclk, 0);
        check("t3_mosi", mosi, 0);
        check("t3_busy", busy, 0);
        check("t3_rxd", rxd, 8'h00);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("t3_no_done", done_cnt, 0);
        start_txn(8'h01, 8'h55, 16'h00C3, e0);
        wait_done(200, at, ok);
        check("t3_done_seen", ok, 1);
        check("t3_done_time", at - e0, 70);
        check("t3_slave_rx", srx, 16'h0155);
        check("t3_rises", rises, 16);
        check("t3_rxd", rxd, 8'hC3);

        @(negedge clk);
        start1 = 1'b1;
        repeat (80) @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 100 && d1.size() < 3; i++) @(negedge clk);
        check("t4_accepts", acc.size(), 3);
        check("t4_dones", d1.size(), 3);
        check("t4_acc1", (acc.size() > 1) ? acc[1] - acc[0] : -1, 36);
        check("t4_acc2", (acc.size() > 2) ? acc[2] - acc[0] : -1, 72);
        check("t4_done0", (d1.size() > 0 && acc.size() > 0) ? d1[0] - acc[0] : -1, 35);
        check("t4_done1", (d1.size() > 1 && acc.size() > 0) ? d1[1] - acc[0] : -1, 71);
        check("t4_rxd", rxd1, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
